// File: rtl/param_ping_pong_counter_v2_if.sv
// param_ping_pong_counter_v2_if: control, bound and status signals of the ping-pong counter
interface param_ping_pong_counter_v2_if #(parameter int WIDTH = 4);
  logic enable, flip, mode, load, direction, tc;
  logic [WIDTH-1:0] max, min, step, load_val, out;
  modport master(output enable, flip, mode, max, min, step, load, load_val, input direction, out, tc);
  modport slave(input enable, flip, mode, max, min, step, load, load_val, output direction, out, tc);
endinterface

// File: rtl/param_ping_pong_counter_v2.sv
// param_ping_pong_counter_v2: bounded up/down counter, ping-pong or wrap; tc pulse only when PPC_TC_PULSE_EN is defined
module param_ping_pong_counter_v2 #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst_n,
  param_ping_pong_counter_v2_if.slave s
);
  logic [WIDTH-1:0] st, up_room, dn_room, cnt_out, out_q;
  logic bad, oor, ed, up_hit, dn_hit, cnt_dir, dir_q;
  // room to each bound is only consulted when out is inside [min,max], so the subtractions never wrap
  always_comb begin
    st = (s.step == '0) ? WIDTH'(1) : s.step;
    bad = s.max <= s.min;
    oor = out_q > s.max || out_q < s.min;
    ed = dir_q ^ s.flip;
    up_room = s.max - out_q;
    dn_room = out_q - s.min;
    up_hit = s.mode ? up_room < st : up_room <= st;
    dn_hit = s.mode ? dn_room < st : dn_room <= st;
    cnt_out = ed ? (up_hit ? (s.mode ? s.min : s.max) : out_q + st)
                 : (dn_hit ? (s.mode ? s.max : s.min) : out_q - st);
    cnt_dir = s.mode ? ed : (ed ? !up_hit : dn_hit);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= s.min;
      dir_q <= 1'b1;
    end else if (s.load) begin
      out_q <= s.load_val;
    end else if (!bad && s.enable) begin
      out_q <= oor ? s.min : cnt_out;
      dir_q <= oor || cnt_dir;
    end
  end
  assign s.out = out_q;
  assign s.direction = dir_q;
`ifdef PPC_TC_PULSE_EN
  logic tc_q;
  always_ff @(posedge clk) tc_q <= rst_n && !s.load && !bad && s.enable && !oor && (ed ? up_hit : dn_hit);
  assign s.tc = tc_q;
`else
  assign s.tc = 1'b0;
`endif
endmodule

// File: tb/tb_param_ping_pong_counter_v2.sv
// tb_param_ping_pong_counter_v2: directed literal sequences plus randomized run against a behavioural model
module tb_param_ping_pong_counter_v2;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0, n_err = 0;
  int m_out = 0, m_dir = 1, m_tc = 0;
  bit chk_en = 1'b0;
  param_ping_pong_counter_v2_if #(.WIDTH(4)) bus();
  param_ping_pong_counter_v2 #(.WIDTH(4)) dut(.clk(clk), .rst_n(rst_n), .s(bus.slave));
  always #5 clk = ~clk;
  function automatic int tcx(int v);
`ifdef PPC_TC_PULSE_EN
    return v;
`else
    return 0;
`endif
  endfunction
  task automatic chk(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask
  task automatic model();
    int mx, mn, s, t;
    bit ed;
    mx = int'(bus.max);
    mn = int'(bus.min);
    if (!rst_n) begin
      m_out = mn; m_dir = 1; m_tc = 0;
    end else if (bus.load) begin
      m_out = int'(bus.load_val); m_tc = 0;
    end else if (mx <= mn || !bus.enable) begin
      m_tc = 0;
    end else if (m_out > mx || m_out < mn) begin
      m_out = mn; m_dir = 1; m_tc = 0;
    end else begin
      s = (bus.step == 0) ? 1 : int'(bus.step);
      ed = m_dir[0] ^ bus.flip;
      t = ed ? m_out + s : m_out - s;
      m_dir = int'(ed);
      m_tc = 1;
      if (!bus.mode) begin
        if (ed && t >= mx) begin m_out = mx; m_dir = 0; end
        else if (!ed && t <= mn) begin m_out = mn; m_dir = 1; end
        else begin m_out = t; m_tc = 0; end
      end else begin
        if (ed && t > mx) m_out = mn;
        else if (!ed && t < mn) m_out = mx;
        else begin m_out = t; m_tc = 0; end
      end
    end
  endtask
  task automatic drive(bit rn, bit ld, bit en, bit fl, bit md, int mx, int mn, int st, int lv);
    rst_n = rn; bus.load = ld; bus.enable = en; bus.flip = fl; bus.mode = md;
    bus.max = 4'(mx); bus.min = 4'(mn); bus.step = 4'(st); bus.load_val = 4'(lv);
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    @(negedge clk);
  endtask
  task automatic lit(string nm, int o, int d, int t);
    chk({nm, ".out"}, int'(bus.out), o);
    chk({nm, ".dir"}, int'(bus.direction), d);
    chk({nm, ".tc"}, int'(bus.tc), tcx(t));
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.out", int'(bus.out), m_out);
      chk("model.dir", int'(bus.direction), m_dir);
      chk("model.tc", int'(bus.tc), tcx(m_tc));
    end
  end
  initial begin
    int e30[9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
    int t30[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    int e31[7] = '{4, 7, 9, 6, 3, 1, 4};
    int t31[7] = '{0, 0, 1, 0, 0, 1, 0};
    int e33[4] = '{2, 4, 0, 2};
    int t33[4] = '{0, 0, 1, 0};
    int mx, mn, st;
    chk_en = 1'b1;
    drive(0, 1, 1, 1, 0, 9, 2, 1, 5); tick(); lit("reset_min2", 2, 1, 0);
    drive(0, 0, 1, 0, 0, 4, 0, 1, 0); tick();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 1, 0, 0, 4, 0, 1, 0); tick();
      chk($sformatf("pp_step1[%0d].out", i), int'(bus.out), e30[i]);
      chk($sformatf("pp_step1[%0d].tc", i), int'(bus.tc), tcx(t30[i]));
    end
    drive(0, 0, 1, 0, 0, 9, 1, 3, 0); tick();
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 1, 0, 0, 9, 1, 3, 0); tick();
      chk($sformatf("pp_step3[%0d].out", i), int'(bus.out), e31[i]);
      chk($sformatf("pp_step3[%0d].tc", i), int'(bus.tc), tcx(t31[i]));
    end
    drive(1, 0, 1, 1, 0, 9, 1, 3, 0); tick(); lit("flip_at_4", 1, 1, 1);
    drive(1, 0, 1, 0, 0, 1, 4, 3, 0); tick(); lit("bad_range", 1, 1, 0);
    drive(1, 1, 1, 0, 0, 1, 4, 3, 8); tick(); lit("load8", 8, 1, 0);
    drive(1, 0, 1, 0, 0, 14, 12, 3, 0); tick(); lit("recover", 12, 1, 0);
    drive(0, 0, 1, 0, 1, 5, 0, 2, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 0, 1, 5, 0, 2, 0); tick();
      chk($sformatf("wrap_up[%0d].out", i), int'(bus.out), e33[i]);
      chk($sformatf("wrap_up[%0d].tc", i), int'(bus.tc), tcx(t33[i]));
    end
    drive(1, 1, 1, 0, 1, 5, 0, 2, 5); tick(); lit("wrap_load5", 5, 1, 0);
    drive(1, 0, 1, 1, 1, 5, 0, 2, 0); tick(); lit("wrap_dn0", 3, 0, 0);
    drive(1, 0, 1, 0, 1, 5, 0, 2, 0); tick(); lit("wrap_dn1", 1, 0, 0);
    drive(1, 0, 1, 0, 1, 5, 0, 2, 0); tick(); lit("wrap_dn2", 5, 0, 1);
    drive(1, 1, 0, 0, 0, 4, 0, 1, 7); tick(); lit("load7_dis", 7, 0, 0);
    drive(1, 0, 1, 0, 0, 4, 0, 1, 0); tick(); lit("load7_rec", 0, 1, 0);
    mx = 9; mn = 2; st = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          mx = $urandom_range(0, 15); mn = $urandom_range(0, 15);
        end else begin
          mn = $urandom_range(0, 12); mx = $urandom_range(mn + 1, 15);
        end
        st = $urandom_range(0, 5);
      end
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, mx, mn, st, $urandom_range(0, 15));
      tick();
    end
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
